bcd_display_scanner: RTL and testbench

Time-multiplexed 4-digit seven-segment driver that consumes the 16-bit packed BCD word (4 digits, `D.DDD`) produced by the fixed-point-to-decimal stage and scans it onto a common-anode display. It holds a frame-coherent snapshot of the BCD word so digits never tear mid-scan, and it produces registered anode, segment and decimal-point outputs. It sits between the decimal conversion stage and the board display pins.

---
 rtl/display_pkg.sv | 23 ++
 rtl/bcd_to_seven_seg.sv | 27 ++
 rtl/bcd_display_scanner.sv | 123 ++++++++++++
 tb/tb_bcd_display_scanner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared glyph tables, scan state type and digit count for the BCD display scanner.
// All glyphs are active-high {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] GLYPH_DASH = 7'h40;

  localparam logic [9:0][6:0] DEC_GLYPHS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [5:0][6:0] HEX_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77
  };

  typedef enum logic {
    BLANK,
    SCAN
  } scan_state_e;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Combinational nibble-to-glyph decoder, active-high output.
// BCD_INVALID_DASH_EN: nibbles above 9 show a dash instead of a hex glyph.
module bcd_to_seven_seg
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] glyph_o
);

`ifndef BCD_INVALID_DASH_EN
  logic [2:0] hex_idx;
  assign hex_idx = 3'(nib_i - 4'd10);
`endif

  always_comb begin
    glyph_o = GLYPH_DASH;
    if (nib_i <= 4'd9) begin
      glyph_o = DEC_GLYPHS[nib_i];
    end
`ifndef BCD_INVALID_DASH_EN
    else begin
      glyph_o = HEX_GLYPHS[hex_idx];
    end
`endif
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit seven-segment scanner with frame-coherent snapshot.
// BCD_INVALID_DASH_EN (decoder): nibbles above 9 show a dash.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [15:0] bcdIn,
  input  logic [3:0]  dpMask,
  output logic [3:0]  anode,
  output logic [6:0]  segment,
  output logic        dp,
  output logic        frameStart
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

  // XOR masks: all-ones inverts for active-low pins
  localparam logic [3:0] AN_OFF  = {4{ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [DW-1:0] div_q, div_d;
  scan_state_e   state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    mask_q, mask_d;
  logic          frame_q, frame_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  assign tick  = (div_q == DIV_MAX);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    mask_d  = mask_q;
    frame_d = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (tick) begin
          snap_d  = bcdIn;
          mask_d  = dpMask;
          idx_d   = 2'd0;
          frame_d = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (tick) begin
          if (idx_q == 2'd3) begin
            snap_d  = bcdIn;
            mask_d  = dpMask;
            idx_d   = 2'd0;
            frame_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // decode from next-state values so outputs land on the tick edge
  assign nib = snap_d[{idx_d, 2'b00} +: 4];

  bcd_to_seven_seg u_dec (
    .nib_i  (nib),
    .glyph_o(glyph)
  );

  always_comb begin
    anode_d = AN_OFF;
    seg_d   = SEG_OFF;
    dp_d    = DP_OFF;
    if (state_d == SCAN) begin
      anode_d = (4'b0001 << idx_d) ^ AN_OFF;
      seg_d   = glyph ^ SEG_OFF;
      dp_d    = mask_d[idx_d] ^ DP_OFF;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      div_q   <= '0;
      state_q <= BLANK;
      idx_q   <= 2'd0;
      snap_q  <= '0;
      mask_q  <= '0;
      frame_q <= 1'b0;
      anode_q <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign anode      = anode_q;
  assign segment    = seg_q;
  assign dp         = dp_q;
  assign frameStart = frame_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: frame-arithmetic model plus directed literal checks.
// Two instances cover active-low and active-high polarity.
module tb_bcd_display_scanner;

  localparam int R = 4;

  logic        clock = 1'b0;
  logic        resetN = 1'b1;
  logic [15:0] bcdIn = 16'h0000;
  logic [3:0]  dpMask = 4'h0;

  logic [3:0] anode_l, anode_h;
  logic [6:0] seg_l, seg_h;
  logic       dp_l, dp_h, fs_l, fs_h;

  int checks = 0;
  int errors = 0;

  bcd_display_scanner #(.REFRESH_DIV(R), .ACTIVE_LOW(1'b1)) dut_l (
    .clock(clock), .resetN(resetN), .bcdIn(bcdIn), .dpMask(dpMask),
    .anode(anode_l), .segment(seg_l), .dp(dp_l), .frameStart(fs_l)
  );

  bcd_display_scanner #(.REFRESH_DIV(R), .ACTIVE_LOW(1'b0)) dut_h (
    .clock(clock), .resetN(resetN), .bcdIn(bcdIn), .dpMask(dpMask),
    .anode(anode_h), .segment(seg_h), .dp(dp_h), .frameStart(fs_h)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef BCD_INVALID_DASH_EN
    if (n > 4'd9) return 7'h40;
`endif
    return tbl[n];
  endfunction

  // model: edges since reset release, ticks every R edges, frame every 4 ticks
  int          m_edges = 0;
  int          m_ticks = 0;
  logic [15:0] m_snap = 16'h0;
  logic [3:0]  m_mask = 4'h0;
  logic        m_fs = 1'b0;

  always @(posedge clock or negedge resetN) begin
    int e, t;
    if (!resetN) begin
      m_edges <= 0;
      m_ticks <= 0;
      m_snap  <= 16'h0;
      m_mask  <= 4'h0;
      m_fs    <= 1'b0;
    end else begin
      e = m_edges + 1;
      t = m_ticks;
      m_edges <= e;
      m_fs    <= 1'b0;
      if (e % R == 0) begin
        t = t + 1;
        m_ticks <= t;
        if ((t - 1) % 4 == 0) begin
          m_snap <= bcdIn;
          m_mask <= dpMask;
          m_fs   <= 1'b1;
        end
      end
    end
  end

  // active-high expectation; the active-low instance expects the inverse
  always @(negedge clock) begin
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    int d;
    ea = 4'h0; es = 7'h0; ed = 1'b0;
    if (m_ticks > 0) begin
      d  = (m_ticks - 1) % 4;
      ea = 4'(1 << d);
      es = glyph_of(m_snap[d*4 +: 4]);
      ed = m_mask[d];
    end
    checks++;
    if ({anode_h, seg_h, dp_h, fs_h} !== {ea, es, ed, m_fs}) begin
      errors++;
      $display("FAIL model_high t=%0t got an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
               $time, anode_h, seg_h, dp_h, fs_h, ea, es, ed, m_fs);
    end
    checks++;
    if ({anode_l, seg_l, dp_l, fs_l} !== {~ea, ~es, ~ed, m_fs}) begin
      errors++;
      $display("FAIL model_low t=%0t got an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
               $time, anode_l, seg_l, dp_l, fs_l, ~ea, ~es, ~ed, m_fs);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_inactive(input string name);
    chk({name, "_low"}, 32'({anode_l, seg_l, dp_l, fs_l}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    chk({name, "_high"}, 32'({anode_h, seg_h, dp_h, fs_h}), 32'h0);
  endtask

  initial begin
    bcdIn  = 16'h0123;
    dpMask = 4'h0;
    #1 resetN = 1'b0;
    edges(2);
    chk_inactive("reset");
    resetN = 1'b1;
    edges(3);
    chk_inactive("blank_pre_tick");
    edges(1);
    chk("first_anode", 32'(anode_l), 32'hE);
    chk("first_seg", 32'(seg_l), 32'h30);
    chk("first_fs", 32'(fs_l), 32'h1);
    edges(5);
    bcdIn = 16'h0999;
    edges(3);
    chk("tear_d2_anode", 32'(anode_l), 32'hB);
    chk("tear_d2_seg", 32'(seg_l), 32'h79);
    edges(4);
    chk("tear_d3_anode", 32'(anode_l), 32'h7);
    chk("tear_d3_seg", 32'(seg_l), 32'h40);
    edges(4);
    chk("new_frame_seg", 32'(seg_l), 32'h10);
    chk("new_frame_fs", 32'(fs_l), 32'h1);
    bcdIn  = 16'h0500;
    dpMask = 4'b1000;
    edges(16);
    chk("dp_d0", 32'(dp_l), 32'h1);
    edges(12);
    chk("dp_d3_seg", 32'(seg_l), 32'h40);
    chk("dp_d3_dp", 32'(dp_l), 32'h0);
    chk("dp_d3_high", 32'(dp_h), 32'h1);
    bcdIn  = 16'h000A;
    dpMask = 4'h0;
    edges(4);
`ifdef BCD_INVALID_DASH_EN
    chk("invalid_seg", 32'(seg_l), 32'h3F);
`else
    chk("invalid_seg", 32'(seg_l), 32'h08);
`endif
    bcdIn = 16'h0008;
    edges(16);
    chk("pol_anode", 32'(anode_h), 32'h1);
    chk("pol_seg", 32'(seg_h), 32'h7F);
    edges(9);
    chk("mid_anode", 32'(anode_l), 32'hB);
    #2 resetN = 1'b0;
    #1 chk_inactive("async_reset");
    edges(2);
    resetN = 1'b1;
    edges(3);
    chk_inactive("restart_blank");
    edges(1);
    chk("restart_anode", 32'(anode_l), 32'hE);
    chk("restart_seg", 32'(seg_l), 32'h00);
    chk("restart_fs", 32'(fs_l), 32'h1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) bcdIn = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dpMask = 4'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        resetN = 1'b0;
        edges(1);
        resetN = 1'b1;
      end
      edges(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
